// File: rtl/demux1to3_buf.sv
// 1-to-3 valid/ready demux. Each accepted word is steered by select_i into one of
// three independent 2-entry FIFOs, so a stalled consumer only blocks its own channel.
module demux1to3_buf #(
   parameter int unsigned size = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [size-1:0] data_i,
   input  logic [1:0]      select_i,
   input  logic            valid_i,
   output logic            ready_o,
   output logic [size-1:0] data0_o,
   output logic [size-1:0] data1_o,
   output logic [size-1:0] data2_o,
   output logic            valid0_o,
   output logic            valid1_o,
   output logic            valid2_o,
   input  logic            ready0_i,
   input  logic            ready1_i,
   input  logic            ready2_i
);

   logic [1:0]                dst;
   logic [2:0]                full;
   logic [2:0]                empty;
   logic [2:0]                push;
   logic [2:0]                pop;
   logic [2:0]                rdy_ch;
   logic [2:0][size-1:0]      head;

   assign rdy_ch = {ready2_i, ready1_i, ready0_i};

   always_comb begin
      dst = 2'd0;
      case (select_i)
         2'b01:   dst = 2'd1;
         2'b10:   dst = 2'd2;
         default: dst = 2'd0;
      endcase
   end

   // Registered full flag only: a same-cycle pop never frees room for a push.
   assign ready_o = ~full[dst];

   for (genvar n = 0; n < 3; n++) begin : g_ch
      logic [size-1:0] mem [2];
      logic            rd_ptr;
      logic            wr_ptr;
      logic [1:0]      count;

      assign full[n]  = (count == 2'd2);
      assign empty[n] = (count == 2'd0);
      assign push[n]  = valid_i & ready_o & (dst == 2'(n));
      assign pop[n]   = ~empty[n] & rdy_ch[n];
      assign head[n]  = mem[rd_ptr];

      always_ff @(posedge clk_i) begin
         if (!rst_i) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
         end else begin
            if (push[n]) begin
               mem[wr_ptr] <= data_i;
               wr_ptr      <= ~wr_ptr;
            end
            if (pop[n]) begin
               rd_ptr <= ~rd_ptr;
            end
            case ({push[n], pop[n]})
               2'b10:   count <= count + 2'd1;
               2'b01:   count <= count - 2'd1;
               default: count <= count;
            endcase
         end
      end
   end

   assign data0_o  = head[0];
   assign data1_o  = head[1];
   assign data2_o  = head[2];
   assign valid0_o = ~empty[0];
   assign valid1_o = ~empty[1];
   assign valid2_o = ~empty[2];

endmodule

// File: tb/tb_demux1to3_buf.sv
// Directed + randomized bench for demux1to3_buf, checked against a queue-based
// model of three bounded per-channel FIFOs.
module tb_demux1to3_buf;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] data_i;
   logic [1:0]  select_i;
   logic        valid_i;
   logic        ready_o;
   logic [31:0] data0_o, data1_o, data2_o;
   logic        valid0_o, valid1_o, valid2_o;
   logic        ready0_i, ready1_i, ready2_i;

   int checks   = 0;
   int failures = 0;

   logic [31:0] q [3][$];
   bit          zero_data [3];
   bit          last_accept;

   demux1to3_buf #(.size(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .select_i(select_i),
      .valid_i(valid_i), .ready_o(ready_o),
      .data0_o(data0_o), .data1_o(data1_o), .data2_o(data2_o),
      .valid0_o(valid0_o), .valid1_o(valid1_o), .valid2_o(valid2_o),
      .ready0_i(ready0_i), .ready1_i(ready1_i), .ready2_i(ready2_i)
   );

   always #5 clk_i = ~clk_i;

   function automatic int chan_of(input logic [1:0] sel);
      if (sel == 2'b01) return 1;
      if (sel == 2'b10) return 2;
      return 0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Compare DUT against model mid-cycle, then advance one clock and update the model.
   task automatic step();
      logic [31:0] dv [3];
      logic        vv [3];
      logic        rr [3];
      int          d;
      bit          exp_ready;
      @(negedge clk_i);
      dv[0] = data0_o;  dv[1] = data1_o;  dv[2] = data2_o;
      vv[0] = valid0_o; vv[1] = valid1_o; vv[2] = valid2_o;
      rr[0] = ready0_i; rr[1] = ready1_i; rr[2] = ready2_i;
      d = chan_of(select_i);
      exp_ready = (q[d].size() < 2);
      for (int n = 0; n < 3; n++) begin
         check($sformatf("valid%0d", n), {31'd0, vv[n]}, {31'd0, q[n].size() > 0});
         if (q[n].size() > 0)
            check($sformatf("data%0d", n), dv[n], q[n][0]);
         else if (zero_data[n])
            check($sformatf("data%0d_zero", n), dv[n], 32'd0);
      end
      check("ready_o", {31'd0, ready_o}, {31'd0, exp_ready});
      @(posedge clk_i);
      last_accept = 1'b0;
      if (!rst_i) begin
         for (int n = 0; n < 3; n++) begin
            q[n].delete();
            zero_data[n] = 1'b1;
         end
      end else begin
         for (int n = 0; n < 3; n++)
            if (q[n].size() > 0 && rr[n]) void'(q[n].pop_front());
         if (valid_i && exp_ready) begin
            q[d].push_back(data_i);
            zero_data[d] = 1'b0;
            last_accept  = 1'b1;
         end
      end
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] sel, input logic [31:0] d);
      valid_i  = v;
      select_i = sel;
      data_i   = d;
      step();
   endtask

   initial begin
      for (int n = 0; n < 3; n++) zero_data[n] = 1'b1;
      ready0_i = 1'b1; ready1_i = 1'b1; ready2_i = 1'b1;

      // Reset held two cycles with a valid word presented
      rst_i = 1'b0;
      drive(1'b1, 2'b00, 32'hAA);
      drive(1'b1, 2'b00, 32'hAA);
      rst_i = 1'b1;
      drive(1'b0, 2'b00, 32'h0);

      // Routing across all select codes
      drive(1'b1, 2'b00, 32'hA1);
      drive(1'b1, 2'b01, 32'hB2);
      drive(1'b1, 2'b10, 32'hC3);
      drive(1'b1, 2'b11, 32'hD4);
      repeat (2) drive(1'b0, 2'b00, 32'h0);

      // Full and backpressure on ch1
      ready1_i = 1'b0;
      drive(1'b1, 2'b01, 32'h11);
      drive(1'b1, 2'b01, 32'h22);
      drive(1'b1, 2'b01, 32'h33);
      drive(1'b1, 2'b01, 32'h33);
      ready1_i = 1'b1;
      drive(1'b1, 2'b01, 32'h33);
      drive(1'b1, 2'b01, 32'h33);
      repeat (3) drive(1'b0, 2'b00, 32'h0);

      // Isolation: ch2 full and stalled while ch0 flows
      ready2_i = 1'b0;
      drive(1'b1, 2'b10, 32'h21);
      drive(1'b1, 2'b10, 32'h22);
      drive(1'b1, 2'b00, 32'h01);
      drive(1'b1, 2'b00, 32'h02);
      drive(1'b0, 2'b00, 32'h0);
      ready2_i = 1'b1;
      repeat (2) drive(1'b0, 2'b00, 32'h0);

      // Concurrent push and pop with ch0 holding one word
      ready0_i = 1'b0;
      drive(1'b1, 2'b00, 32'h5);
      ready0_i = 1'b1;
      drive(1'b1, 2'b00, 32'h6);
      ready0_i = 1'b0;
      drive(1'b0, 2'b00, 32'h0);
      check("concurrent_data0", data0_o, 32'h6);
      ready0_i = 1'b1;
      drive(1'b0, 2'b00, 32'h0);

      // Mid-operation reset with every FIFO full
      ready0_i = 1'b0; ready1_i = 1'b0; ready2_i = 1'b0;
      for (int i = 0; i < 6; i++)
         drive(1'b1, 2'(i % 3), 32'h100 + 32'(i));
      rst_i = 1'b0;
      drive(1'b0, 2'b00, 32'h0);
      rst_i = 1'b1;
      drive(1'b0, 2'b00, 32'h0);
      ready0_i = 1'b1; ready1_i = 1'b1; ready2_i = 1'b1;
      drive(1'b1, 2'b10, 32'h77);
      drive(1'b0, 2'b00, 32'h0);

      // Randomized traffic; an unaccepted word is held until taken
      for (int c = 0; c < 400; c++) begin
         ready0_i = ($urandom_range(0, 3) != 0);
         ready1_i = ($urandom_range(0, 1) != 0);
         ready2_i = ($urandom_range(0, 4) == 0);
         rst_i    = ($urandom_range(0, 99) != 0);
         if (!(valid_i && !last_accept)) begin
            valid_i  = ($urandom_range(0, 2) != 0);
            select_i = 2'($urandom_range(0, 3));
            data_i   = $urandom;
         end
         step();
      end
      rst_i   = 1'b1;
      valid_i = 1'b0;
      ready0_i = 1'b1; ready1_i = 1'b1; ready2_i = 1'b1;
      repeat (3) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
